vga_plot_arbiter: RTL

- Shares the single VGA pixel-write port (VGA_X, VGA_Y, VGA_COLOR, plot) among NREQ independent drawing engines.
- Uses round-robin arbitration with valid/ready handshakes, one pixel per cycle.
- Contains a built-in screen-clear sequencer that takes priority over all requesters and sweeps the whole frame with one colour.
- Sits between the demo drawing engines and the top-level VGA outputs.

---
 rtl/vga_plot_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/vga_plot_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/vga_plot_pkg.sv
// Shared types and resolution constants for the VGA pixel-write arbiter.
// Define VGA_640_480 or VGA_320_240 to select a larger frame; the default is 160x120.
package vga_plot_pkg;

`ifdef VGA_640_480
  localparam int unsigned RES_XW   = 10;
  localparam int unsigned RES_XMAX = 640;
  localparam int unsigned RES_YMAX = 480;
`elsif VGA_320_240
  localparam int unsigned RES_XW   = 9;
  localparam int unsigned RES_XMAX = 320;
  localparam int unsigned RES_YMAX = 240;
`else
  localparam int unsigned RES_XW   = 8;
  localparam int unsigned RES_XMAX = 160;
  localparam int unsigned RES_YMAX = 120;
`endif

  localparam int unsigned RES_YW = RES_XW - 1;
  localparam int unsigned RES_CW = 24;

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic [RES_XW-1:0] x;
    logic [RES_YW-1:0] y;
    logic [RES_CW-1:0] color;
  } pixel_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap,
// and moves the pointer past the winner only when a transfer is taken.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_req,
  input  logic                 i_advance,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_grant_idx
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] r_ptr;
  logic          w_found;

  always_comb begin : search
    int unsigned k;
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    k           = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (int'(r_ptr) + i) % N;
      if (!w_found && i_req[k]) begin
        w_found     = 1'b1;
        o_grant[k]  = 1'b1;
        o_grant_idx = IW'(k);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares one VGA pixel-write port among NREQ drawing engines, with a
// full-screen clear sequencer that pre-empts all requesters.
module vga_plot_arbiter
  import vga_plot_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XW   = RES_XW,
  parameter int unsigned YW   = RES_YW,
  parameter int unsigned XMAX = RES_XMAX,
  parameter int unsigned YMAX = RES_YMAX,
  parameter int unsigned CW   = RES_CW
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*XW-1:0] req_x,
  input  logic [NREQ*YW-1:0] req_y,
  input  logic [NREQ*CW-1:0] req_color,
  output logic [NREQ-1:0]    req_ready,
  input  logic               clear_start,
  input  logic [CW-1:0]      clear_color,
  output logic               busy,
  output logic               clear_done,
  output logic [XW-1:0]      VGA_X,
  output logic [YW-1:0]      VGA_Y,
  output logic [CW-1:0]      VGA_COLOR,
  output logic               plot
);

  localparam int unsigned IW = $clog2(NREQ);

  state_t          r_state, w_state_nxt;
  logic [XW-1:0]   r_cx, r_vx;
  logic [YW-1:0]   r_cy, r_vy;
  logic [CW-1:0]   r_ccolor, r_vcolor;
  logic            r_plot, r_done;

  logic [NREQ-1:0] w_arb_req, w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_xfer, w_step, w_start, w_last;

  // Requesters are hidden from the arbiter whenever a clear is running or starting.
  assign w_arb_req = (r_state == IDLE && !clear_start) ? req_valid : '0;
  assign w_xfer    = |(req_valid & w_grant);
  assign req_ready = w_grant;

  rr_arbiter #(.N(NREQ)) u_rr (
    .i_clk       (CLOCK_50),
    .i_rst       (reset),
    .i_req       (w_arb_req),
    .i_advance   (w_xfer),
    .o_grant     (w_grant),
    .o_grant_idx (w_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_step      = (r_state == CLEAR);
    w_start     = (r_state == IDLE) && clear_start;
    w_last      = w_step && (r_cx == XW'(XMAX - 1)) && (r_cy == YW'(YMAX - 1));
    case (r_state)
      IDLE:    if (clear_start) w_state_nxt = CLEAR;
      CLEAR:   if (w_last)      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cx     <= '0;
      r_cy     <= '0;
      r_ccolor <= '0;
      r_vx     <= '0;
      r_vy     <= '0;
      r_vcolor <= '0;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_plot  <= w_xfer | w_step;
      r_done  <= w_last;
      if (w_step) begin
        r_vx     <= r_cx;
        r_vy     <= r_cy;
        r_vcolor <= r_ccolor;
      end else if (w_xfer) begin
        r_vx     <= req_x[int'(w_idx)*XW +: XW];
        r_vy     <= req_y[int'(w_idx)*YW +: YW];
        r_vcolor <= req_color[int'(w_idx)*CW +: CW];
      end
      if (w_start) begin
        r_cx     <= '0;
        r_cy     <= '0;
        r_ccolor <= clear_color;
      end else if (w_step) begin
        if (r_cx == XW'(XMAX - 1)) begin
          r_cx <= '0;
          r_cy <= r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end
    end
  end

  assign busy       = (r_state == CLEAR);
  assign clear_done = r_done;
  assign VGA_X      = r_vx;
  assign VGA_Y      = r_vy;
  assign VGA_COLOR  = r_vcolor;
  assign plot       = r_plot;

endmodule
